adder_subtractor_bk: RTL and testbench
======================================

# adder_subtractor_bk

Registered 32-bit adder with carry-in, built on a Brent-Kung parallel-prefix carry network. It computes `sum = A + B + cin` with carry-out and is the arithmetic core of the datapath. An optional compile-time subtract control adds two's-complement subtraction. The carry logic is a structural prefix tree, not a behavioural `+`, so it can be compared against an operator-based reference adder.

## Interface
- `WIDTH`, default 32: operand width; must be a power of two, at least 2.
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset; one clock; reset is synchronous and active-high.
- `A` input WIDTH: operand A, unsigned or two's complement.
- `B` input WIDTH: operand B.
- `cin` input 1: carry-in into bit 0.
- `sub` input 1: present only with `ADDSUB_BK_SUB_EN`; 1 selects subtract.
- `sum` output WIDTH: registered result, low WIDTH bits.
- `cout` output 1: registered carry out of the MSB.

## Operation
- Effective operand `Bx`:
  - default: `Bx = B`.
  - with `ADDSUB_BK_SUB_EN`: `Bx = sub ? ~B : B`.
- Per bit: `g[i] = A[i] & Bx[i]`, `p[i] = A[i] ^ Bx[i]`.
- `cin` is folded in as the generate term of a virtual bit −1, so `c[0] = cin`.
- Up-sweep: log2(WIDTH) levels of the prefix operator `(G,P)∘(G',P') = (G | P&G', P&P')` at stride 2^k.
- Down-sweep: log2(WIDTH)−1 levels that fill in the remaining carries.
- Result bits: `s[i] = p[i] ^ c[i]`; carry-out `co = c[WIDTH]`.
- No `+` or `-` operator anywhere in the datapath.
- Arithmetic is exact modulo 2^WIDTH:
  - `{co, s} = A + Bx + cin` as a (WIDTH+1)-bit unsigned value.
  - Overflow wraps. No signed-overflow flag.
- Subtract (`sub=1`): `A + ~B + cin`.
  - `cin=1` gives `A − B`.
  - `cin=0` gives `A − B − 1` (borrow-in).
  - `cout=1` means no borrow (A ≥ B unsigned, when `cin=1`).
- All inputs are don't-care while `rst` is high.

## Timing
- Prefix network is combinational; `{cout, sum}` is registered on the rising edge of `clk`.
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N and hold until edge N+1.
- Throughput 1 operation per cycle; no handshake, no stall.
- Reset:
  - `rst=1` at an edge sets `sum=0`, `cout=0`. Reset has priority over any operand.
  - Reset asserted mid-stream discards the in-flight result.
  - The first valid result appears one edge after the first non-reset sampling edge.
- Back-to-back operand changes each cycle produce a matching result stream, one cycle delayed.
- Outputs are undefined only before the first clock edge.

## Configuration
- `ADDSUB_BK_SUB_EN` defined:
  - `sub` port exists.
  - `Bx` is conditionally inverted by one XOR per bit ahead of the g/p stage.
- Not defined:
  - No `sub` port; the block is a pure adder, `Bx = B`.
  - Benches must not drive `sub`.
- Latency and reset behaviour are identical in both builds.

## Structure
- Shared package `adder_bk_pkg`:
  - `ADD_WIDTH = 32`.
  - `ADD_LEVELS = $clog2(ADD_WIDTH)`.
  - `typedef` of the generate/propagate pair struct.
- Sub-module `bk_prefix_tree`:
  - Purely combinational.
  - Inputs: `g`, `p` vectors plus `cin`.
  - Output: carry vector `c[WIDTH:0]`.
  - Built with generate loops over the up-sweep and down-sweep levels.
- Top level holds operand conditioning, the sum XOR and the output register.

## Test plan
Check each result one cycle after applying the operands.
- Reset: `rst=1` for 2 cycles with `A=FFFFFFFF`, `B=FFFFFFFF`, `cin=1` -> `sum=00000000`, `cout=0`.
  - Then assert `rst` mid-stream -> outputs clear on the next edge.
- `A=0000000F`, `B=00000001`, `cin=1` -> `sum=00000011`, `cout=0`.
- `A=FFFFFFFF`, `B=00000001`, `cin=0` -> `sum=00000000`, `cout=1` (wrap).
- Back-to-back, one per cycle:
  - `12345678 + 87654321 + 1` -> `9999999A`, `cout=0`.
  - `87654321 + 12345678 + 0` -> `99999999`, `cout=0`.
  - `80000000 + 80000000 + 1` -> `00000001`, `cout=1`.
- With `ADDSUB_BK_SUB_EN`:
  - `sub=1`, `A=00000010`, `B=00000001`, `cin=1` -> `0000000F`, `cout=1`.
  - `sub=1`, `A=00000000`, `B=00000001`, `cin=1` -> `FFFFFFFF`, `cout=0`.
- Random: 10,000 random `A`, `B`, `cin` (and `sub`) -> `{cout, sum}` equals the `+`-operator model on every cycle.

Source files
------------

// File: rtl/adder_bk_pkg.sv
// -----------------------------------------------------------------------------
// adder_bk_pkg
// Shared definitions for the Brent-Kung adder/subtractor.
//   ADD_WIDTH  : default operand width (power of two, >= 2)
//   ADD_LEVELS : number of up-sweep levels of the prefix tree
//   gp_t       : generate/propagate pair carried through the prefix network
//   gp_combine : the prefix operator (G,P) o (G',P') = (G | P&G', P&P')
// -----------------------------------------------------------------------------
package adder_bk_pkg;

    localparam int ADD_WIDTH  = 32;
    localparam int ADD_LEVELS = $clog2(ADD_WIDTH);

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // hi covers the more significant span, lo the adjacent less significant one.
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/adder_subtractor_bk_prefix_tree.sv
// -----------------------------------------------------------------------------
// bk_prefix_tree
// Purely combinational Brent-Kung carry network.
// Ports:
//   g   [WIDTH-1:0] in  : per-bit generate
//   p   [WIDTH-1:0] in  : per-bit propagate
//   cin             in  : carry into bit 0
//   c   [WIDTH:0]   out : c[i] is the carry into bit i, c[WIDTH] is carry-out
// -----------------------------------------------------------------------------
module bk_prefix_tree
    import adder_bk_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    input  logic             cin,
    output logic [WIDTH:0]   c
);

    localparam int LEVELS = $clog2(WIDTH);
    // Stage 0 holds the bit-level pairs, stages 1..LEVELS are the up-sweep,
    // stages LEVELS+1 .. 2*LEVELS-1 are the down-sweep.
    localparam int STAGES = 2 * LEVELS;

    gp_t node [0:STAGES-1][0:WIDTH-1];

    generate
        // cin acts as the generate of a virtual bit -1, so it is absorbed into
        // bit 0 here; every group ending at bit 0 then already includes it.
        for (genvar i = 0; i < WIDTH; i++) begin : g_stage0
            if (i == 0) begin : g_bit0
                assign node[0][i] = gp_combine(gp_t'{g: g[i], p: p[i]},
                                               gp_t'{g: cin, p: 1'b0});
            end else begin : g_bitn
                assign node[0][i] = gp_t'{g: g[i], p: p[i]};
            end
        end

        // Up-sweep: level k combines bit i with i - 2^(k-1) where i+1 is a
        // multiple of 2^k. After it, bits 2^k-1 hold full prefixes.
        for (genvar k = 1; k <= LEVELS; k++) begin : g_up
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                if (((i + 1) % (1 << k)) == 0) begin : g_op
                    assign node[k][i] = gp_combine(node[k-1][i],
                                                   node[k-1][i - (1 << (k-1))]);
                end else begin : g_pass
                    assign node[k][i] = node[k-1][i];
                end
            end
        end

        // Down-sweep: levels run with shrinking span J = LEVELS-1 .. 1 and
        // fill in the bits sitting halfway between already-complete prefixes.
        for (genvar m = 1; m < LEVELS; m++) begin : g_down
            localparam int J = LEVELS - m;
            localparam int S = LEVELS + m;
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                if ((((i + 1) % (1 << J)) == (1 << (J-1))) && (i >= (1 << J))) begin : g_op
                    assign node[S][i] = gp_combine(node[S-1][i],
                                                   node[S-1][i - (1 << (J-1))]);
                end else begin : g_pass
                    assign node[S][i] = node[S-1][i];
                end
            end
        end

        assign c[0] = cin;
        for (genvar i = 0; i < WIDTH; i++) begin : g_carry
            assign c[i+1] = node[STAGES-1][i].g;
        end
    endgenerate

endmodule

// File: rtl/adder_subtractor_bk.sv
// -----------------------------------------------------------------------------
// adder_subtractor_bk
// Registered WIDTH-bit adder, {cout,sum} = A + Bx + cin, carries from a
// Brent-Kung prefix tree. Latency 1 cycle, one operation per cycle, no
// handshake: every clock edge captures a new result.
// Optional macro ADDSUB_BK_SUB_EN adds the 'sub' port; sub=1 uses Bx = ~B so
// cin=1 yields A-B and cout=1 means "no borrow".
// Ports:
//   clk              in  : rising-edge clock
//   rst              in  : synchronous active-high reset, clears sum/cout
//   A, B [WIDTH-1:0] in  : operands
//   cin              in  : carry-in into bit 0
//   sub              in  : (ADDSUB_BK_SUB_EN only) 1 selects subtract
//   sum  [WIDTH-1:0] out : registered result
//   cout             out : registered carry out of the MSB
// -----------------------------------------------------------------------------
module adder_subtractor_bk
    import adder_bk_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
`ifdef ADDSUB_BK_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;

    always_comb begin
`ifdef ADDSUB_BK_SUB_EN
        bx = B ^ {WIDTH{sub}};
`else
        bx = B;
`endif
        g = A & bx;
        p = A ^ bx;
    end

    bk_prefix_tree #(.WIDTH(WIDTH)) u_tree (
        .g   (g),
        .p   (p),
        .cin (cin),
        .c   (c)
    );

    always_comb begin
        sum_d  = p ^ c[WIDTH-1:0];
        cout_d = c[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_adder_subtractor_bk.sv
// -----------------------------------------------------------------------------
// tb_adder_subtractor_bk
// Driver applies one vector per cycle on the falling edge and pushes the
// expected {cout,sum} into exp_q; the monitor pops one entry after every
// rising edge and compares.
// -----------------------------------------------------------------------------
module tb_adder_subtractor_bk;

  logic        clk;
  logic        rst;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        cin_i;
  logic        sub_i;
  logic [31:0] sum_o;
  logic        cout_o;

  logic [32:0] exp_q[$];
  string       name_q[$];
  int          n_checks;
  int          n_fail;

  adder_subtractor_bk #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (a_i),
    .B    (b_i),
    .cin  (cin_i),
`ifdef ADDSUB_BK_SUB_EN
    .sub  (sub_i),
`endif
    .sum  (sum_o),
    .cout (cout_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // driver
  task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic s, input logic [32:0] e,
                       input string nm);
    @(negedge clk);
    rst   = r;
    a_i   = a;
    b_i   = b;
    cin_i = ci;
    sub_i = s;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    logic [32:0] e;
    string       nm;
    #1;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if ({cout_o, sum_o} !== e) begin
        n_fail++;
        $display("FAIL %s: got cout=%b sum=%08h, expected cout=%b sum=%08h",
                 nm, cout_o, sum_o, e[32], e[31:0]);
      end
    end
  end

  initial begin
    logic [31:0] ra, rb, rbx;
    logic        rc, rs;
    logic [32:0] re;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;

    // reset with all-ones operands must still yield zero
    drive(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 33'h0_00000000, "reset0");
    drive(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 33'h0_00000000, "reset1");

    drive(0, 32'h0000000F, 32'h00000001, 1, 0, 33'h0_00000011, "add_f_1_c1");
    drive(0, 32'hFFFFFFFF, 32'h00000001, 0, 0, 33'h1_00000000, "wrap");

    // back-to-back stream
    drive(0, 32'h12345678, 32'h87654321, 1, 0, 33'h0_9999999A, "b2b0");
    drive(0, 32'h87654321, 32'h12345678, 0, 0, 33'h0_99999999, "b2b1");
    drive(0, 32'h80000000, 32'h80000000, 1, 0, 33'h1_00000001, "b2b2");
    drive(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 33'h1_FFFFFFFF, "all_ones");
    drive(0, 32'hFFFFFFFF, 32'h00000000, 1, 0, 33'h1_00000000, "carry_chain");
    drive(0, 32'h00000000, 32'h00000000, 0, 0, 33'h0_00000000, "zero");

    // reset mid-stream discards the in-flight result
    drive(0, 32'h00000005, 32'h00000003, 0, 0, 33'h0_00000008, "pre_rst");
    drive(1, 32'h0000FFFF, 32'h00000001, 1, 0, 33'h0_00000000, "mid_rst");
    drive(0, 32'h00000001, 32'h00000002, 0, 0, 33'h0_00000003, "post_rst");

`ifdef ADDSUB_BK_SUB_EN
    drive(0, 32'h00000010, 32'h00000001, 1, 1, 33'h1_0000000F, "sub_16_1");
    drive(0, 32'h00000000, 32'h00000001, 1, 1, 33'h0_FFFFFFFF, "sub_0_1");
    drive(0, 32'h00000010, 32'h00000001, 0, 1, 33'h1_0000000E, "sub_borrow_in");
    drive(0, 32'h00000007, 32'h00000007, 1, 1, 33'h1_00000000, "sub_equal");
`endif

    // random against the + operator model
    for (int n = 0; n < 10000; n++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
`ifdef ADDSUB_BK_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      rbx = rs ? ~rb : rb;
      re  = {1'b0, ra} + {1'b0, rbx} + {32'b0, rc};
      drive(0, ra, rb, rc, rs, re, "random");
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results never observed, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
